rx_block_packer: RTL

Receive-side counterpart of the transmit byte FIFO: collects bytes from the UART receiver and packs them, first byte most-significant, into one 64-bit block for the SIMON decryption core. It holds each completed block until the consumer acknowledges it. It flags bytes lost to overrun, and discards stale partial blocks after an idle timeout.

---
 rtl/rx_block_packer_pkg.sv | 26 ++
 rtl/rx_idle_timer.sv | 57 +++++
 rtl/rx_block_packer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/rx_block_packer_pkg.sv
// rx_block_packer_pkg
//   Definitions shared by the UART receive and transmit paths.
//   - Byte and block geometry. Byte lane 0 is the most-significant byte of a block.
//     The transmit byte FIFO uses the same byte order.
//   - The receive packer state encoding.
//   - The idle timeout for a 100 MHz system clock.
//   - A helper that maps a byte lane to its most-significant bit position.
package rx_block_packer_pkg;

  localparam int RX_DATA_SIZE      = 8;
  localparam int RX_WORDS          = 8;
  localparam int RX_BLOCK_W        = RX_DATA_SIZE * RX_WORDS;
  // 100 ms at 100 MHz.
  localparam int RX_TIMEOUT_100MHZ = 10_000_000;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } pack_state_e;

  // Returns the MSB index of a byte lane. Lane 0 sits at the top of the block.
  function automatic int lane_msb(input int lane, input int data_size, input int words);
    return (words - lane) * data_size - 1;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// rx_idle_timer
//   Idle counter for the receive packer. The counter is cleared to 0.
//   - It advances on every cycle that enable is high.
//   - When it reaches its terminal value, it gives a one-cycle expired pulse
//     and returns to 0.
//   - clear has priority over enable.
// Ports
//   clk_100MHz  in  system clock
//   reset       in  synchronous active-high reset
//   clear       in  return counter to 0 (a byte was accepted)
//   enable      in  count this cycle (partial block pending, no byte)
//   expired     out combinational pulse in the terminal cycle
module rx_idle_timer
  import rx_block_packer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_100MHZ
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The terminal value is TIMEOUT_CYCLES-2. The parent registers the expiry,
  // so the visible drop pulse lands exactly TIMEOUT_CYCLES cycles after
  // the last accepted byte.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == TERM) begin
        cnt_d   = '0;
        expired = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_block_packer.sv
// rx_block_packer
//   Packs bytes from the UART receiver into one block for the decryption core.
//   - The first byte received becomes the most-significant byte of the block.
//   - A completed block is held until the consumer takes it.
//   - A byte that arrives while a block is held and not released is dropped.
//     The sticky overrun flag is then set.
//   - A partial block is discarded after an idle timeout.
// Ports
//   clk_100MHz    in  system clock
//   reset         in  synchronous active-high reset
//   rx_data       in  received byte
//   rx_valid      in  one-cycle strobe qualifying rx_data
//   block_ready   in  consumer accepts block_out this cycle
//   block_out     out assembled block (registered)
//   block_valid   out block_out holds a complete, unacknowledged block
//   byte_count    out bytes collected in the current partial block
//   overrun       out sticky; a byte was dropped because the block was held
//   partial_drop  out one-cycle pulse; a partial block timed out
//
// state   | meaning
// --------+--------------------------------------------------------------
// COLLECT | accepting bytes into lane byte_count
// FULL    | block complete, block_valid=1, waiting for block_ready
module rx_block_packer
  import rx_block_packer_pkg::*;
#(
  parameter int DATA_SIZE      = RX_DATA_SIZE,
  parameter int WORDS          = RX_WORDS,
  parameter int TIMEOUT_CYCLES = RX_TIMEOUT_100MHZ
) (
  input  logic                         clk_100MHz,
  input  logic                         reset,
  input  logic [DATA_SIZE-1:0]         rx_data,
  input  logic                         rx_valid,
  input  logic                         block_ready,
  output logic [DATA_SIZE*WORDS-1:0]   block_out,
  output logic                         block_valid,
  output logic [$clog2(WORDS)-1:0]     byte_count,
  output logic                         overrun,
  output logic                         partial_drop
);

  localparam int BLOCK_W = DATA_SIZE * WORDS;
  localparam int CNT_W   = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(WORDS - 1);

  pack_state_e        state_q, state_d;
  logic [CNT_W-1:0]   byte_count_q, byte_count_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic               overrun_q, overrun_d;
  logic               partial_drop_q, partial_drop_d;

  logic accept;
  logic last_byte;
  logic idle_en;
  logic expired;

  // State register.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A release and a new block completion in the same
  // cycle can only happen when WORDS is 1. It is still handled.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (last_byte) state_d = FULL;
      FULL:    if (block_ready) state_d = last_byte ? FULL : COLLECT;
    endcase
  end

  // Outputs and control decoded from the current state.
  // In FULL, a strobe is taken only when the held block leaves in the same
  // cycle. That gives zero-bubble back-to-back blocks.
  always_comb begin
    block_valid = (state_q == FULL);
    accept      = rx_valid && ((state_q == COLLECT) || block_ready);
    last_byte   = accept && (byte_count_q == LAST_LANE);
    idle_en     = (state_q == COLLECT) && (byte_count_q != '0) && !rx_valid;
  end

  rx_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clear      (accept),
    .enable     (idle_en),
    .expired    (expired)
  );

  // Datapath next values. byte_count is always 0 in FULL, so a byte taken
  // on release lands in lane 0 of the next block.
  always_comb begin
    block_d        = block_q;
    byte_count_d   = byte_count_q;
    overrun_d      = overrun_q;
    partial_drop_d = 1'b0;

    if (accept) begin
      block_d[lane_msb(int'(byte_count_q), DATA_SIZE, WORDS) -: DATA_SIZE] = rx_data;
      byte_count_d = last_byte ? '0 : byte_count_q + CNT_W'(1);
    end else if (expired) begin
      // Stale lanes stay in place; the next block overwrites them.
      byte_count_d   = '0;
      partial_drop_d = 1'b1;
    end

    if (rx_valid && !accept) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      byte_count_q   <= '0;
      block_q        <= '0;
      overrun_q      <= 1'b0;
      partial_drop_q <= 1'b0;
    end else begin
      byte_count_q   <= byte_count_d;
      block_q        <= block_d;
      overrun_q      <= overrun_d;
      partial_drop_q <= partial_drop_d;
    end
  end

  assign block_out    = block_q;
  assign byte_count   = byte_count_q;
  assign overrun      = overrun_q;
  assign partial_drop = partial_drop_q;

endmodule
